// File: rtl/exec_pkg.sv
// Shared encodings, widths and FSM state for the execute stage.
// Optional EXEC_TRAP_EN build adds a sticky overflow trap.
package exec_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    localparam logic [2:0] FN_AND = 3'b000;
    localparam logic [2:0] FN_OR  = 3'b001;
    localparam logic [2:0] FN_ADD = 3'b010;
    localparam logic [2:0] FN_SUB = 3'b110;
    localparam logic [2:0] FN_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    function automatic logic fn_legal(input logic [2:0] fn);
        return fn inside {FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT};
    endfunction

    // slt is evaluated by the ALU as a subtract; the set flag carries the answer
    function automatic logic [2:0] fn_to_op(input logic [2:0] fn);
        return (fn == FN_SLT) ? FN_SUB : fn;
    endfunction
endpackage

// File: rtl/exec_if.sv
// Instruction issue / completion bundle between the issuer and exec_unit.
// master = issuer side, slave = execute stage.
interface exec_if;
    import exec_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fn;
    logic [ADDR_W-1:0] in_rs;
    logic [ADDR_W-1:0] in_rt;
    logic [ADDR_W-1:0] in_rd;

    logic              out_valid;
    logic [ADDR_W-1:0] out_rd;
    logic [DATA_W-1:0] out_data;
    logic              out_zero;
    logic              out_ovf;
    logic              out_err;

    modport master (
        output in_valid, in_fn, in_rs, in_rt, in_rd,
        input  in_ready,
        input  out_valid, out_rd, out_data, out_zero, out_ovf, out_err
    );

    modport slave (
        input  in_valid, in_fn, in_rs, in_rt, in_rd,
        output in_ready,
        output out_valid, out_rd, out_data, out_zero, out_ovf, out_err
    );
endinterface

// File: rtl/exec_regfile.sv
// 32x32 register file: three combinational reads, one synchronous write.
// r0 is hardwired to zero; the whole array clears on reset.
module exec_regfile
    import exec_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);
    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rs_data  = (rs == '0) ? '0 : mem[rs];
    assign rt_data  = (rt == '0) ? '0 : mem[rt];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
endmodule

// File: rtl/exec_unit.sv
// Three-cycle execute stage (IDLE/EXEC/WB) around an external combinational ALU.
// Define EXEC_TRAP_EN to add a sticky overflow trap that blocks further issue.
module exec_unit
    import exec_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    exec_if.slave             bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_set,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata
`ifdef EXEC_TRAP_EN
    ,
    output logic              trap
`endif
);
    state_t            state;
    state_t            state_nxt;
    logic              in_ready;
    logic              accept;
    logic              in_exec;
    logic              dbg_wr;
    logic              locked;
    logic [2:0]        fn_q;
    logic [ADDR_W-1:0] rd_q;
    logic              legal;
    logic              ovf;
    logic              trap_hit;
    logic              wb_we;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (state == IDLE) && !locked;
        accept       = bus.in_valid && in_ready;
        in_exec      = (state == EXEC);
        dbg_wr       = dbg_we && (state == IDLE);
        bus.in_ready = in_ready;
    end

`ifdef EXEC_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset)              trap <= 1'b0;
        else if (in_exec && ovf) trap <= 1'b1;
    end
    assign locked   = trap;
    assign trap_hit = ovf;
`else
    assign locked   = 1'b0;
    assign trap_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            fn_q   <= '0;
            rd_q   <= '0;
        end else if (accept) begin
            alu_a  <= rs_data;
            alu_b  <= rt_data;
            alu_op <= fn_to_op(bus.in_fn);
            fn_q   <= bus.in_fn;
            rd_q   <= bus.in_rd;
        end
    end

    always_comb begin
        legal   = fn_legal(fn_q);
        ovf     = alu_overflow && (fn_q == FN_ADD || fn_q == FN_SUB);
        wb_data = '0;
        unique case (1'b1)
            !legal:           wb_data = '0;
            (fn_q == FN_SLT): wb_data = {{(DATA_W-1){1'b0}}, alu_set};
            default:          wb_data = alu_result;
        endcase
        wb_we = in_exec && legal && !trap_hit;
    end

    // dbg writes only happen in IDLE, so they never collide with writeback
    assign rf_we    = wb_we || dbg_wr;
    assign rf_waddr = wb_we ? rd_q : dbg_addr;
    assign rf_wdata = wb_we ? wb_data : dbg_wdata;

    exec_regfile u_rf (
        .clk      (clk),
        .reset    (reset),
        .rs       (bus.in_rs),
        .rt       (bus.in_rt),
        .dbg_addr (dbg_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .dbg_data (dbg_rdata),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_rd    <= '0;
            bus.out_data  <= '0;
            bus.out_zero  <= 1'b0;
            bus.out_ovf   <= 1'b0;
            bus.out_err   <= 1'b0;
        end else begin
            bus.out_valid <= in_exec;
            if (in_exec) begin
                bus.out_rd   <= rd_q;
                bus.out_data <= wb_data;
                bus.out_zero <= legal && alu_zero;
                bus.out_ovf  <= ovf;
                bus.out_err  <= !legal;
            end
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit with a behavioural ALU model.
// Covers EXEC_TRAP_EN and default builds.
module tb_exec_unit;
    import exec_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_set;
    logic        alu_zero;
    logic        alu_overflow;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;
`ifdef EXEC_TRAP_EN
    logic        trap;
`endif

    exec_if bus ();

    exec_unit dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_set      (alu_set),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .dbg_we       (dbg_we),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_rdata    (dbg_rdata)
`ifdef EXEC_TRAP_EN
        ,
        .trap         (trap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // classic gate-level ALU behaviour: set = sign of (a-b) corrected by overflow
    logic [31:0] m_sum;
    logic [31:0] m_diff;
    logic        m_sub_ovf;
    always_comb begin
        m_sum     = alu_a + alu_b;
        m_diff    = alu_a - alu_b;
        m_sub_ovf = (alu_a[31] != alu_b[31]) && (m_diff[31] != alu_a[31]);
        alu_overflow = 1'b0;
        case (alu_op)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010: begin
                alu_result   = m_sum;
                alu_overflow = (alu_a[31] == alu_b[31]) && (m_sum[31] != alu_a[31]);
            end
            3'b110: begin
                alu_result   = m_diff;
                alu_overflow = m_sub_ovf;
            end
            default: alu_result = 32'h0;
        endcase
        alu_set  = m_diff[31] ^ m_sub_ovf;
        alu_zero = (alu_result == 32'h0);
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
        dbg_we    = 1'b1;
        dbg_addr  = a;
        dbg_wdata = d;
        @(negedge clk);
        dbg_we = 1'b0;
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [31:0] d);
        dbg_addr = a;
        #1;
        d = dbg_rdata;
    endtask

    logic [31:0] cap_data;
    logic [4:0]  cap_rd;
    logic        cap_zero;
    logic        cap_ovf;
    logic        cap_err;

    task automatic issue(input logic [2:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
        chk("ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_fn    = fn;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_rd    = rd;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("ready_exec", bus.in_ready, 0);
        chk("no_early_pulse", bus.out_valid, 0);
        @(negedge clk);
        chk("pulse", bus.out_valid, 1);
        chk("ready_wb", bus.in_ready, 0);
        cap_data = bus.out_data;
        cap_rd   = bus.out_rd;
        cap_zero = bus.out_zero;
        cap_ovf  = bus.out_ovf;
        cap_err  = bus.out_err;
        @(negedge clk);
        chk("pulse_one_cycle", bus.out_valid, 0);
    endtask

    typedef struct {
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        zero;
        logic        ovf;
        logic        err;
        logic        wr;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [31:0] sent;
        logic [31:0] exp_r;
        int pulses;
        int acc;
        int last;
        bit acc_prev;

        vecs[0]  = '{FN_ADD, 32'd5,        32'd7,        5'd3,  32'd12,       1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{FN_SUB, 32'd3,        32'd3,        5'd4,  32'd0,        1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{FN_SLT, 32'hFFFFFFFF, 32'd1,        5'd8,  32'd1,        1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{FN_SLT, 32'd1,        32'hFFFFFFFF, 5'd11, 32'd0,        1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{FN_SLT, 32'h80000000, 32'd1,        5'd15, 32'd1,        1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{FN_AND, 32'hF0F000FF, 32'h0FF00F0F, 5'd9,  32'h00F0000F, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{FN_AND, 32'h000000F0, 32'h0000000F, 5'd14, 32'd0,        1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{FN_OR,  32'hF0000000, 32'h0000000F, 5'd10, 32'hF000000F, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{FN_SUB, 32'd2,        32'd5,        5'd12, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{3'b011, 32'd5,        32'd7,        5'd6,  32'd0,        1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{3'b100, 32'd5,        32'd7,        5'd13, 32'd0,        1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{FN_ADD, 32'd5,        32'd7,        5'd0,  32'd12,       1'b0, 1'b0, 1'b0, 1'b1};

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_fn    = '0;
        bus.in_rs    = '0;
        bus.in_rt    = '0;
        bus.in_rd    = '0;
        dbg_we       = 1'b0;
        dbg_addr     = '0;
        dbg_wdata    = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_ready", bus.in_ready, 1);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_err", bus.out_err, 0);
        rd_reg(5'd5, r);
        chk("rst_r5", r, 0);

        for (int i = 0; i < 12; i++) begin
            sent = 32'hA5A50000 | i;
            dbg_write(5'd1, vecs[i].a);
            dbg_write(5'd2, vecs[i].b);
            dbg_write(vecs[i].rd, sent);
            issue(vecs[i].fn, 5'd1, 5'd2, vecs[i].rd);
            chk($sformatf("v%0d_data", i), cap_data, vecs[i].data);
            chk($sformatf("v%0d_rd", i), cap_rd, vecs[i].rd);
            chk($sformatf("v%0d_zero", i), cap_zero, vecs[i].zero);
            chk($sformatf("v%0d_ovf", i), cap_ovf, vecs[i].ovf);
            chk($sformatf("v%0d_err", i), cap_err, vecs[i].err);
            chk($sformatf("v%0d_hold", i), bus.out_data, vecs[i].data);
            exp_r = (vecs[i].rd == 5'd0) ? 32'd0 : (vecs[i].wr ? vecs[i].data : sent);
            rd_reg(vecs[i].rd, r);
            chk($sformatf("v%0d_reg", i), r, exp_r);
        end

        // back-to-back issue with in_valid held high
        dbg_write(5'd1, 32'd1);
        dbg_write(5'd2, 32'd2);
        pulses   = 0;
        acc      = 0;
        last     = -1;
        acc_prev = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (bus.out_valid) begin
                pulses++;
                if (last >= 0) chk("b2b_gap", cyc - last, 3);
                last = cyc;
                chk("b2b_ready_wb", bus.in_ready, 0);
            end
            if (acc_prev) chk("b2b_ready_exec", bus.in_ready, 0);
            acc_prev     = 1'b0;
            bus.in_valid = (acc < 4);
            bus.in_fn    = FN_ADD;
            bus.in_rs    = 5'd1;
            bus.in_rt    = 5'd2;
            bus.in_rd    = 5'd16;
            if (bus.in_valid && bus.in_ready) begin
                acc++;
                acc_prev = 1'b1;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("b2b_pulses", pulses, 4);
        rd_reg(5'd16, r);
        chk("b2b_r16", r, 3);

        // debug write on the accept edge: operand sees the old value
        dbg_write(5'd17, 32'd100);
        dbg_we       = 1'b1;
        dbg_addr     = 5'd17;
        dbg_wdata    = 32'd200;
        bus.in_valid = 1'b1;
        bus.in_fn    = FN_ADD;
        bus.in_rs    = 5'd17;
        bus.in_rt    = 5'd0;
        bus.in_rd    = 5'd18;
        @(negedge clk);
        bus.in_valid = 1'b0;
        dbg_addr     = 5'd19;
        dbg_wdata    = 32'd55;
        @(negedge clk);
        dbg_we = 1'b0;
        chk("same_edge_data", bus.out_data, 100);
        @(negedge clk);
        rd_reg(5'd17, r);
        chk("same_edge_r17", r, 200);
        rd_reg(5'd18, r);
        chk("same_edge_r18", r, 100);
        rd_reg(5'd19, r);
        chk("dbg_busy_ignored", r, 0);

        // reset while in EXEC abandons the instruction
        dbg_write(5'd1, 32'd5);
        dbg_write(5'd2, 32'd7);
        bus.in_valid = 1'b1;
        bus.in_fn    = FN_ADD;
        bus.in_rs    = 5'd1;
        bus.in_rt    = 5'd2;
        bus.in_rd    = 5'd7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_exec_valid", bus.out_valid, 0);
        chk("rst_exec_ready", bus.in_ready, 1);
        chk("rst_exec_alu_a", alu_a, 0);
        @(negedge clk);
        chk("rst_exec_valid2", bus.out_valid, 0);
        rd_reg(5'd7, r);
        chk("rst_exec_r7", r, 0);
        dbg_write(5'd1, 32'd5);
        dbg_write(5'd2, 32'd7);
        issue(FN_ADD, 5'd1, 5'd2, 5'd7);
        rd_reg(5'd7, r);
        chk("recover_r7", r, 12);

        // signed overflow on add
        dbg_write(5'd1, 32'h7FFFFFFF);
        dbg_write(5'd2, 32'd1);
        dbg_write(5'd5, 32'h55555555);
        issue(FN_ADD, 5'd1, 5'd2, 5'd5);
        chk("ovf_flag", cap_ovf, 1);
        chk("ovf_data", cap_data, 32'h80000000);
        chk("ovf_err", cap_err, 0);
`ifdef EXEC_TRAP_EN
        rd_reg(5'd5, r);
        chk("trap_r5", r, 32'h55555555);
        chk("trap_set", trap, 1);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("trap_ready", bus.in_ready, 0);
            @(negedge clk);
            chk("trap_no_pulse", bus.out_valid, 0);
        end
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("trap_cleared", trap, 0);
        chk("trap_ready_after_rst", bus.in_ready, 1);
`else
        rd_reg(5'd5, r);
        chk("ovf_r5", r, 32'h80000000);
        chk("ovf_ready", bus.in_ready, 1);
        dbg_write(5'd1, 32'h80000000);
        issue(FN_SUB, 5'd1, 5'd2, 5'd20);
        chk("sub_ovf_flag", cap_ovf, 1);
        rd_reg(5'd20, r);
        chk("sub_ovf_r20", r, 32'h7FFFFFFF);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
